// File: rtl/fetch_ctrl_pkg.sv
// Shared types and default widths for the fetch controller slice.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam int PC_W_DEF      = 8;
    localparam int OFF_W_DEF     = 6;
    localparam int RAS_DEPTH_DEF = 4;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Control/status bundle between the sequencer (master) and the fetch controller (slave).
interface fetch_ctrl_if
    import fetch_ctrl_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int OFF_W = OFF_W_DEF
);
    logic             Start;
    logic [PC_W-1:0]  Start_Addr;
    logic             Stall;
    logic             Branch;
    logic             Zero;
    logic [OFF_W-1:0] Offset;
    logic             Jump;
    logic             Call;
    logic             Ret;
    logic [PC_W-1:0]  Jump_Addr;
    logic             Halt;
    logic [PC_W-1:0]  PC;
    logic             Valid;
    logic             Halted;
    logic             Ras_Empty;
    logic             Ras_Full;
    logic             Ras_Err;

    modport master (
        output Start, Start_Addr, Stall, Branch, Zero, Offset,
               Jump, Call, Ret, Jump_Addr, Halt,
        input  PC, Valid, Halted, Ras_Empty, Ras_Full, Ras_Err
    );

    modport slave (
        input  Start, Start_Addr, Stall, Branch, Zero, Offset,
               Jump, Call, Ret, Jump_Addr, Halt,
        output PC, Valid, Halted, Ras_Empty, Ras_Full, Ras_Err
    );

endinterface

// File: rtl/fetch_ctrl_ret_stack.sv
// Circular return-address stack: a push while full overwrites the oldest entry.
module ret_stack #(
    parameter int PC_W  = 8,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic            clear,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] top,
    output logic            empty,
    output logic            full,
    output logic            overflow,
    output logic            underflow
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [PC_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] top_idx;

    // ptr is the next write slot; the newest entry sits just below it
    assign top_idx   = ptr - PTR_ONE;
    assign top       = mem[top_idx];
    assign empty     = (count == '0);
    assign full      = (count == CNT_MAX);
    assign overflow  = push && !clear && full;
    assign underflow = pop && !clear && empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            count <= '0;
        end else if (clear) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            ptr <= ptr + PTR_ONE;
            if (!full) count <= count + CNT_ONE;
        end else if (pop && !empty) begin
            ptr   <= ptr - PTR_ONE;
            count <= count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Program-counter sequencer: start, increment, relative branch, jump, call/return, stall, halt.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int OFF_W     = OFF_W_DEF,
    parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic         CLK,
    input  logic         Reset_n,
    fetch_ctrl_if.slave  bus
);
    fetch_state_t    state, state_nxt;
    logic [PC_W-1:0] pc, pc_nxt;
    logic [PC_W-1:0] pc_inc, pc_br, off_ext, ras_top;
    logic            ras_err;
    logic            push, pop, clear;
    logic            ras_empty, ras_full, ras_ovf, ras_unf;

    assign off_ext = {{(PC_W-OFF_W){bus.Offset[OFF_W-1]}}, bus.Offset};
    assign pc_inc  = pc + PC_W'(1);
    assign pc_br   = pc + off_ext;

    ret_stack #(
        .PC_W  (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (CLK),
        .rst_n     (Reset_n),
        .push      (push),
        .pop       (pop),
        .clear     (clear),
        .push_data (pc_inc),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .overflow  (ras_ovf),
        .underflow (ras_unf)
    );

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            pc    <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    // Start wins in every state; in RUN: Stall > Halt > Ret > Call > Jump > Branch > increment
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        push      = 1'b0;
        pop       = 1'b0;
        clear     = 1'b0;
        if (bus.Start) begin
            state_nxt = RUN;
            pc_nxt    = bus.Start_Addr;
            clear     = 1'b1;
        end else if (state == RUN && !bus.Stall) begin
            if (bus.Halt) begin
                state_nxt = HALT;
            end else if (bus.Ret) begin
                pop    = 1'b1;
                pc_nxt = ras_empty ? pc_inc : ras_top;
            end else if (bus.Call) begin
                push   = 1'b1;
                pc_nxt = bus.Jump_Addr;
            end else if (bus.Jump) begin
                pc_nxt = bus.Jump_Addr;
            end else if (bus.Branch && bus.Zero) begin
                pc_nxt = pc_br;
            end else begin
                pc_nxt = pc_inc;
            end
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n)              ras_err <= 1'b0;
        else if (clear)            ras_err <= 1'b0;
        else if (ras_ovf || ras_unf) ras_err <= 1'b1;
    end

    assign bus.PC        = pc;
    assign bus.Valid     = (state == RUN);
    assign bus.Halted    = (state == HALT);
    assign bus.Ras_Empty = ras_empty;
    assign bus.Ras_Full  = ras_full;
    assign bus.Ras_Err   = ras_err;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed and randomized bench for fetch_ctrl with a queue-based reference model.
module tb_fetch_ctrl;
    logic CLK;
    logic Reset_n;
    int   total;
    int   bad;

    fetch_ctrl_if #(.PC_W(8), .OFF_W(6)) bus ();

    fetch_ctrl #(.PC_W(8), .OFF_W(6), .RAS_DEPTH(4)) dut (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Reference model: running/halted flags, PC and the return stack as a bounded queue
    logic [7:0] m_pc;
    bit         m_run;
    bit         m_halt;
    bit         m_err;
    logic [7:0] m_ras [$];

    task automatic model_reset();
        m_pc   = 8'h00;
        m_run  = 1'b0;
        m_halt = 1'b0;
        m_err  = 1'b0;
        m_ras.delete();
    endtask

    task automatic model_step();
        logic [7:0] nxt;
        logic [7:0] ext;
        nxt = m_pc + 8'd1;
        ext = {{2{bus.Offset[5]}}, bus.Offset};
        if (!Reset_n) begin
            model_reset();
        end else if (bus.Start) begin
            m_pc = bus.Start_Addr; m_run = 1'b1; m_halt = 1'b0;
            m_err = 1'b0; m_ras.delete();
        end else if (m_run && !bus.Stall) begin
            if (bus.Halt) begin
                m_run = 1'b0; m_halt = 1'b1;
            end else if (bus.Ret) begin
                if (m_ras.size() > 0) m_pc = m_ras.pop_back();
                else begin m_pc = nxt; m_err = 1'b1; end
            end else if (bus.Call) begin
                m_ras.push_back(nxt);
                if (m_ras.size() > 4) begin
                    void'(m_ras.pop_front());
                    m_err = 1'b1;
                end
                m_pc = bus.Jump_Addr;
            end else if (bus.Jump) m_pc = bus.Jump_Addr;
            else if (bus.Branch && bus.Zero) m_pc = m_pc + ext;
            else m_pc = nxt;
        end
    endtask

    task automatic check(input string tag);
        logic e_empty, e_full;
        e_empty = (m_ras.size() == 0);
        e_full  = (m_ras.size() == 4);
        total += 6;
        assert (bus.PC === m_pc) else begin
            bad++; $error("FAIL %s pc got=%h exp=%h", tag, bus.PC, m_pc); end
        assert (bus.Valid === m_run) else begin
            bad++; $error("FAIL %s valid got=%b exp=%b", tag, bus.Valid, m_run); end
        assert (bus.Halted === m_halt) else begin
            bad++; $error("FAIL %s halted got=%b exp=%b", tag, bus.Halted, m_halt); end
        assert (bus.Ras_Empty === e_empty) else begin
            bad++; $error("FAIL %s ras_empty got=%b exp=%b", tag, bus.Ras_Empty, e_empty); end
        assert (bus.Ras_Full === e_full) else begin
            bad++; $error("FAIL %s ras_full got=%b exp=%b", tag, bus.Ras_Full, e_full); end
        assert (bus.Ras_Err === m_err) else begin
            bad++; $error("FAIL %s ras_err got=%b exp=%b", tag, bus.Ras_Err, m_err); end
    endtask

    task automatic expect_const(input string tag, input logic [7:0] pc, input logic err);
        total += 2;
        assert (bus.PC === pc) else begin
            bad++; $error("FAIL %s pc got=%h exp=%h", tag, bus.PC, pc); end
        assert (bus.Ras_Err === err) else begin
            bad++; $error("FAIL %s ras_err got=%b exp=%b", tag, bus.Ras_Err, err); end
    endtask

    task automatic clr();
        bus.Start = 1'b0; bus.Start_Addr = 8'h00; bus.Stall = 1'b0;
        bus.Branch = 1'b0; bus.Zero = 1'b0; bus.Offset = 6'h00;
        bus.Jump = 1'b0; bus.Call = 1'b0; bus.Ret = 1'b0;
        bus.Jump_Addr = 8'h00; bus.Halt = 1'b0;
    endtask

    task automatic cyc(input string tag);
        @(posedge CLK);
        model_step();
        #1;
        check(tag);
        clr();
    endtask

    logic [7:0] hold_pc;

    initial begin
        total = 0;
        bad   = 0;
        clr();
        model_reset();
        Reset_n = 1'b0;
        cyc("reset0");
        cyc("reset1");
        @(negedge CLK);
        Reset_n = 1'b1;
        cyc("idle");
        expect_const("idle_pc", 8'h00, 1'b0);

        // start and sequential fetch
        bus.Start = 1'b1; bus.Start_Addr = 8'h10; cyc("start");
        expect_const("start_pc", 8'h10, 1'b0);
        cyc("seq1"); cyc("seq2"); cyc("seq3");
        expect_const("seq3_pc", 8'h13, 1'b0);

        // relative branches
        bus.Jump = 1'b1; bus.Jump_Addr = 8'h20; cyc("jmp20");
        bus.Branch = 1'b1; bus.Zero = 1'b1; bus.Offset = 6'h3C; cyc("br_neg");
        expect_const("br_neg_pc", 8'h1C, 1'b0);
        bus.Jump = 1'b1; bus.Jump_Addr = 8'h20; cyc("jmp20b");
        bus.Branch = 1'b1; bus.Zero = 1'b0; bus.Offset = 6'h3C; cyc("br_nt");
        expect_const("br_nt_pc", 8'h21, 1'b0);
        bus.Jump = 1'b1; bus.Jump_Addr = 8'hFE; cyc("jmpFE");
        bus.Branch = 1'b1; bus.Zero = 1'b1; bus.Offset = 6'h03; cyc("br_wrap");
        expect_const("br_wrap_pc", 8'h01, 1'b0);

        // nested call/return
        bus.Jump = 1'b1; bus.Jump_Addr = 8'h30; cyc("jmp30");
        bus.Call = 1'b1; bus.Jump_Addr = 8'h80; cyc("call80");
        bus.Call = 1'b1; bus.Jump_Addr = 8'h90; cyc("call90");
        bus.Ret = 1'b1; cyc("ret1");
        expect_const("ret1_pc", 8'h81, 1'b0);
        bus.Ret = 1'b1; cyc("ret2");
        expect_const("ret2_pc", 8'h31, 1'b0);

        // overflow, drain, underflow, clear by Start
        bus.Start = 1'b1; bus.Start_Addr = 8'h00; cyc("start0");
        for (int k = 0; k < 5; k++) begin
            bus.Call = 1'b1; bus.Jump_Addr = 8'(8'h40 + 8'(k * 16)); cyc("call_ovf");
        end
        expect_const("ovf_pc", 8'h80, 1'b1);
        bus.Ret = 1'b1; cyc("drain1");
        expect_const("drain1_pc", 8'h71, 1'b1);
        for (int k = 0; k < 3; k++) begin
            bus.Ret = 1'b1; cyc("drain");
        end
        expect_const("drain4_pc", 8'h41, 1'b1);
        bus.Ret = 1'b1; cyc("unf");
        expect_const("unf_pc", 8'h42, 1'b1);
        bus.Start = 1'b1; bus.Start_Addr = 8'h00; cyc("start_clr");
        expect_const("start_clr", 8'h00, 1'b0);

        // stall beats jump; halt freezes PC
        bus.Stall = 1'b1; bus.Jump = 1'b1; bus.Jump_Addr = 8'hAA; cyc("stall");
        expect_const("stall_pc", 8'h00, 1'b0);
        cyc("pre_halt");
        bus.Halt = 1'b1; cyc("halt");
        hold_pc = m_pc;
        for (int k = 0; k < 10; k++) begin
            bus.Jump = 1'b1; bus.Jump_Addr = 8'h55; bus.Call = 1'(k[0]);
            cyc("halted");
            expect_const("halt_hold", hold_pc, 1'b0);
        end

        // randomized traffic
        bus.Start = 1'b1; bus.Start_Addr = 8'($urandom); cyc("rnd_start");
        for (int n = 0; n < 600; n++) begin
            bus.Start      = ($urandom_range(39) == 0);
            bus.Start_Addr = 8'($urandom);
            bus.Stall      = ($urandom_range(5) == 0);
            bus.Halt       = ($urandom_range(29) == 0);
            bus.Ret        = ($urandom_range(4) == 0);
            bus.Call       = ($urandom_range(4) == 0);
            bus.Jump       = ($urandom_range(7) == 0);
            bus.Branch     = ($urandom_range(2) == 0);
            bus.Zero       = 1'($urandom);
            bus.Offset     = 6'($urandom);
            bus.Jump_Addr  = 8'($urandom);
            cyc("rnd");
        end

        // asynchronous reset mid-RUN
        bus.Start = 1'b1; bus.Start_Addr = 8'h60; cyc("pre_rst");
        cyc("pre_rst2");
        #1;
        Reset_n = 1'b0;
        #1;
        model_reset();
        check("async_rst");
        expect_const("async_rst_pc", 8'h00, 1'b0);
        @(negedge CLK);
        Reset_n = 1'b1;
        cyc("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
